// File: rtl/filter_seq_pkg.sv
// Shared types and default geometry for the 3x3 window sequencer.
package filter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } seq_state_t;

  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int WIN_LAT   = H_ACT_DEF + 1;

  // Window latency in beats: one full line plus one pixel.
  function automatic int win_lat(input int h_act);
    return h_act + 1;
  endfunction

endpackage

// File: rtl/filter_window_sequencer_xy_counter.sv
// Raster x/y counter: x wraps at H_ACT and carries into y; y never wraps.
module xy_counter
  import filter_seq_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int XW    = 10,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/filter_window_sequencer.sv
// Frame controller for the 3x3 line-buffer/filter datapath: drives line-buffer
// writes, hides the window latency, flushes the last row and tags results.
module filter_window_sequencer
  import filter_seq_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter int XW    = 10,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_we,
  output logic          lb_pad,
  output logic [XW-1:0] lb_x,
  output logic [YW-1:0] lb_y,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_border,
  output logic          busy,
  output logic          frame_done
);

  localparam int LAT = win_lat(H_ACT);
  localparam int BW  = $clog2(LAT + 1);

  localparam logic [XW-1:0] X_LAST     = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_ACT - 1);
  localparam logic [BW-1:0] B_FILL_END = BW'(H_ACT);
  localparam logic [BW-1:0] B_FLUSHED  = BW'(LAT);

  seq_state_t r_state, w_next;

  logic [BW-1:0] r_beat;
  logic          r_out_valid, r_out_border, r_frame_done;
  logic [XW-1:0] r_out_x;
  logic [YW-1:0] r_out_y;

  logic          w_in_ready, w_beat, w_pad, w_prod, w_last;
  logic          w_clr, w_beat_clr;
  logic [XW-1:0] w_ix, w_ox;
  logic [YW-1:0] w_iy, w_oy;
  logic          w_border;

  xy_counter #(.H_ACT(H_ACT), .XW(XW), .YW(YW)) u_in_xy (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_beat),
    .i_clr (w_clr),
    .o_x   (w_ix),
    .o_y   (w_iy)
  );

  xy_counter #(.H_ACT(H_ACT), .XW(XW), .YW(YW)) u_out_xy (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_prod),
    .i_clr (w_clr),
    .o_x   (w_ox),
    .o_y   (w_oy)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_beat     = 1'b0;
    w_pad      = 1'b0;
    w_prod     = 1'b0;
    w_last     = 1'b0;
    w_clr      = 1'b0;
    w_beat_clr = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next     = FILL;
          w_clr      = 1'b1;
          w_beat_clr = 1'b1;
        end
      end
      FILL: begin
        w_in_ready = 1'b1;
        w_beat     = in_valid;
        if (in_valid && r_beat == B_FILL_END) w_next = RUN;
      end
      RUN: begin
        w_in_ready = 1'b1;
        w_beat     = in_valid;
        w_prod     = in_valid;
        if (in_valid && w_ix == X_LAST && w_iy == Y_LAST) begin
          w_next     = FLUSH;
          w_beat_clr = 1'b1;
        end
      end
      FLUSH: begin
        // One idle FLUSH cycle after the last beat keeps busy high alongside frame_done.
        if (r_beat != B_FLUSHED) begin
          w_beat = 1'b1;
          w_pad  = 1'b1;
          w_prod = 1'b1;
          w_last = (r_beat == B_FILL_END);
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Beat index is only needed while filling and while flushing.
  always_ff @(posedge clk) begin
    if (reset || w_beat_clr) r_beat <= '0;
    else if (w_beat && r_state != RUN) r_beat <= r_beat + BW'(1);
  end

  assign w_border = (w_ox == '0) || (w_ox == X_LAST) ||
                    (w_oy == '0) || (w_oy == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_border <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_x      <= '0;
      r_out_y      <= '0;
    end else begin
      r_out_valid  <= w_prod;
      r_out_border <= w_prod & w_border;
      r_frame_done <= w_last;
      if (w_prod) begin
        r_out_x <= w_ox;
        r_out_y <= w_oy;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign lb_we      = w_beat;
  assign lb_pad     = w_pad;
  assign lb_x       = w_ix;
  assign lb_y       = w_iy;
  assign out_valid  = r_out_valid;
  assign out_x      = r_out_x;
  assign out_y      = r_out_y;
  assign out_border = r_out_border;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_filter_window_sequencer.sv
// Directed bench for filter_window_sequencer with an 8x4 frame.
module tb_filter_window_sequencer;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int XW = 4;
  localparam int YW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, lb_we, lb_pad, out_valid, out_border, busy, frame_done;
  logic [XW-1:0] lb_x, out_x;
  logic [YW-1:0] lb_y, out_y;

  filter_window_sequencer #(.H_ACT(H), .V_ACT(V), .XW(XW), .YW(YW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lb_we      (lb_we),
    .lb_pad     (lb_pad),
    .lb_x       (lb_x),
    .lb_y       (lb_y),
    .out_valid  (out_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_border (out_border),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int ox[$];
  int oy[$];
  int ob[$];
  int beats, pads, acc, dones, done_idx, first_beats;
  int pad_x, pad_y, first_x, first_y;
  logic prev_we, last_busy;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_log();
    ox.delete(); oy.delete(); ob.delete();
    beats = 0; pads = 0; acc = 0; dones = 0; done_idx = -1; first_beats = -1;
    pad_x = -1; pad_y = -1; first_x = -1; first_y = -1;
    prev_we = 1'b0; last_busy = 1'b0;
  endtask

  task automatic sample();
    if (out_valid) begin
      chk("out_after_beat", int'(prev_we), 1);
      if (ox.size() == 0) first_beats = beats;
      ox.push_back(int'(out_x));
      oy.push_back(int'(out_y));
      ob.push_back(int'(out_border));
    end
    if (frame_done) begin
      chk("done_with_valid", int'(out_valid), 1);
      dones++;
      done_idx = ox.size() - 1;
    end
    if (lb_we) begin
      if (beats == 0) begin first_x = int'(lb_x); first_y = int'(lb_y); end
      beats++;
      if (lb_pad) begin
        if (pads == 0) begin pad_x = int'(lb_x); pad_y = int'(lb_y); end
        pads++;
      end
    end
    if (in_valid && in_ready) acc++;
    prev_we   = lb_we;
    last_busy = busy;
  endtask

  task automatic step(input logic s, input logic v);
    start    = s;
    in_valid = v;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs until frame_done is observed; stops on the frame_done cycle.
  task automatic run_frame(input bit do_start, input bit gaps, input int start_mid);
    int cyc = 0;
    if (do_start) step(1'b1, 1'b1);
    while (dones == 0 && cyc < 400) begin
      step(cyc == start_mid, gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      cyc++;
    end
    chk("frame_timeout", int'(dones > 0), 1);
  endtask

  task automatic check_frame();
    chk("n_out", ox.size(), H * V);
    chk("n_pad", pads, H + 1);
    chk("n_acc", acc, H * V);
    chk("first_latency", first_beats, H + 2);
    chk("done_count", dones, 1);
    chk("done_idx", done_idx, H * V - 1);
    chk("flush_x", pad_x, 0);
    chk("flush_y", pad_y, V);
    chk("first_lb_x", first_x, 0);
    chk("first_lb_y", first_y, 0);
    for (int i = 0; i < ox.size() && i < H * V; i++) begin
      chk("out_xy", ox[i] * 16 + oy[i], (i % H) * 16 + i / H);
      chk("out_border", ob[i],
          int'((i % H) == 0 || (i % H) == H - 1 || (i / H) == 0 || (i / H) == V - 1));
    end
    if (ox.size() >= H * V) begin
      chk("border_0_0", ob[0], 1);
      chk("border_3_1", ob[11], 0);
      chk("border_7_2", ob[23], 1);
      chk("border_4_3", ob[28], 1);
    end
  endtask

  initial begin
    clr_log();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_lb_we", int'(lb_we), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_lb_xy", int'(lb_x) + int'(lb_y), 0);
    @(posedge clk); #1;

    // Continuous input frame.
    clr_log();
    run_frame(1'b1, 1'b0, -1);
    check_frame();
    step(1'b0, 1'b0);
    chk("busy_after_done", int'(last_busy), 0);

    // Stalled input with a start pulse mid-frame, then a back-to-back start.
    clr_log();
    run_frame(1'b1, 1'b1, 40);
    check_frame();
    step(1'b1, 1'b1);
    chk("b2b_busy_on_start", int'(last_busy), 0);
    chk("b2b_ready_on_start", int'(prev_we), 0);
    clr_log();
    run_frame(1'b0, 1'b0, -1);
    check_frame();
    step(1'b0, 1'b0);

    // Abort with reset after 20 accepts.
    clr_log();
    step(1'b1, 1'b1);
    for (int i = 0; i < 100 && acc < 20; i++) step(1'b0, 1'b1);
    chk("abort_acc", acc, 20);
    reset = 1'b1;
    step(1'b0, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_lb_we", int'(lb_we), 0);
    chk("abort_lb_pad", int'(lb_pad), 0);
    chk("abort_lb_xy", int'(lb_x) + int'(lb_y), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_xy", int'(out_x) + int'(out_y), 0);
    chk("abort_out_border", int'(out_border), 0);
    chk("abort_frame_done", int'(frame_done), 0);
    @(posedge clk); #1;

    // Start coincident with reset is dropped.
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("start_during_reset", int'(busy), 0);
    @(posedge clk); #1;

    clr_log();
    run_frame(1'b1, 1'b0, -1);
    check_frame();
    step(1'b0, 1'b0);
    chk("busy_after_done2", int'(last_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/filter_window_sequencer.md
Name: filter_window_sequencer

Overview:
Frame-level controller for the 3x3 line-buffer / filter datapath (LineBuffer feeding Gaussian, Median or Sobel filters). It accepts a raster pixel stream with a valid/ready handshake and drives the line buffer's write strobe and x/y coordinates. It absorbs the one-line-plus-one-pixel window latency and generates the trailing flush beats needed to drain the last row. It tags each filter result with its true pixel coordinate and a border flag, so downstream logic never re-derives the pipeline offset.

Parameters:
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame
XW, 10, width of x coordinates (must hold H_ACT)
YW, 10, width of y coordinates (must hold V_ACT + 1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begins a frame; ignored while busy
in_valid  in  1  source presents a pixel (pixel data goes straight to the line buffer)
in_ready  out  1  sequencer accepts a pixel this cycle
lb_we  out  1  line-buffer shift/write strobe
lb_pad  out  1  line buffer must load zero data (flush beats)
lb_x  out  XW  line-buffer write column
lb_y  out  YW  line-buffer write row
out_valid  out  1  filter result is valid for (out_x, out_y)
out_x  out  XW  result column
out_y  out  YW  result row
out_border  out  1  result window touches the image edge
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse with the final out_valid

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0, state IDLE, all counters 0. Reset asserted mid-frame aborts immediately; no frame_done is issued.
- States: IDLE, FILL, RUN, FLUSH.
- IDLE: in_ready=0. On start, go to FILL and clear the input counter (ix,iy) and the beat count.
- Beat definition: a beat is either an accepted pixel (in_valid & in_ready) or a flush cycle.
- lb_we = 1 on every beat (combinational from the handshake in FILL/RUN). lb_x/lb_y equal the current (ix,iy) during that beat.
- (ix,iy) advance after each beat. ix wraps H_ACT-1 -> 0 and increments iy.
- Accepted pixels with in_valid=0: no beat occurs, counters hold, and no out_valid is produced on the next cycle. Stalls may occur anywhere.
- FILL: in_ready=1. The first H_ACT+1 beats produce no output. The beat with index H_ACT+1 enters RUN.
- RUN: in_ready=1. Beat index k (k >= H_ACT+1) yields result pixel p = k-(H_ACT+1). out_valid is registered one cycle after the beat, with out_x = p mod H_ACT and out_y = p div H_ACT.
- Acceptance of pixel (H_ACT-1, V_ACT-1) moves to FLUSH.
- FLUSH: in_ready=0. The sequencer issues exactly H_ACT+1 back-to-back beats with lb_we=1 and lb_pad=1. lb_x/lb_y continue counting from (0, V_ACT). Outputs continue per the RUN rule.
- The last flush beat produces pixel (H_ACT-1, V_ACT-1). frame_done=1 in the same cycle as that out_valid, then the sequencer returns to IDLE (busy drops on the following cycle).
- out_valid count per frame is exactly H_ACT*V_ACT, in raster order, with no gaps other than input stalls.
- out_border = (out_x==0) | (out_x==H_ACT-1) | (out_y==0) | (out_y==V_ACT-1). It is only meaningful while out_valid=1 and is held 0 otherwise.
- start during a frame is ignored. start on the same cycle as reset is ignored (reset wins).
- A start pulse in the cycle after frame_done is accepted (back-to-back frames).

Decomposition:
- Shared package filter_seq_pkg: state enum (IDLE, FILL, RUN, FLUSH), default H_ACT/V_ACT constants, and the WIN_LAT = H_ACT+1 latency constant.
- Sub-module xy_counter (enable, clear, wrap at H_ACT, x/y outputs).
- xy_counter is instantiated twice: once for the input/line-buffer coordinates and once for the output coordinates.

Test Plan:
1. H_ACT=8, V_ACT=4, start then in_valid held 1 -> first out_valid (0,0) with out_border=1 one cycle after the 10th accepted beat; in_ready drops after 32 accepts.
2. Same config, full frame -> exactly 32 out_valid in raster order, 9 lb_pad beats, and frame_done coincident with out (7,3); busy=0 on the next cycle.
3. Random in_valid gaps (about 50%) -> identical out_x/out_y sequence to scenario 2, and no out_valid in the cycle after a non-accepting cycle.
4. out (3,1) -> out_border=0; out (7,2) -> out_border=1; out (4,3) -> out_border=1.
5. reset pulsed after 20 accepts -> all outputs 0 next cycle, state IDLE; a new start then reproduces scenario 2 exactly.
6. start pulsed mid-frame, and start in the cycle after frame_done -> the first is ignored; the second begins a new frame with lb_x/lb_y = (0,0).
